reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-003 ALU_REQ / ALU_ADDR / ALU_DATA  input  1/3/8  ALU writeback request, destination register, result.
REQ-004 MEM_REQ / MEM_ADDR / MEM_DATA  input  1/3/8  load writeback request, destination register, load data; held until granted.
REQ-005 BUSYWAIT  input  1  data-memory stall; register writes forbidden while 1.
REQ-006 ALU_GNT  output  1  combinational; ALU request accepted this cycle.
REQ-007 MEM_GNT  output  1  registered one-cycle pulse; load writeback issued.
REQ-008 RF_WRITE / RF_ADDR / RF_DATA  output  1/3/8  registered write port to register file (WRITE, INADDRESS, IN).
REQ-009 STALL  output  1  combinational; ALU writeback buffer full, CPU must hold.
REQ-010 STATE  output  2  current FSM state, debug only.

Function
REQ-011 Single register-file write port SHALL be shared between ALU and load writebacks; at most one write issued per cycle.
REQ-012 ALU results that cannot issue SHALL enter a 2-entry FIFO of {addr[2:0], data[7:0]}; FIFO order SHALL be preserved.
REQ-013 Issue priority per edge: (1) BUSYWAIT=1 -> no write; (2) FIFO non-empty -> issue FIFO head; (3) MEM_REQ -> issue load, MEM_GNT=1; (4) ALU_REQ with FIFO empty -> issue ALU directly; (5) else RF_WRITE=0.
REQ-014 Any accepted ALU_REQ not issued directly (cases 1-3) SHALL be enqueued the same edge.
REQ-015 Simultaneous enqueue and dequeue SHALL leave count unchanged and lose no entry.
REQ-016 STALL SHALL equal (count==2); ALU_GNT SHALL equal ALU_REQ and not STALL; ungranted ALU requests SHALL not be enqueued.
REQ-017 MEM_REQ SHALL not be granted while FIFO non-empty or BUSYWAIT=1 (older ALU results write first).
REQ-018 Latency: request at edge N -> RF_WRITE/RF_ADDR/RF_DATA valid after edge N, for one cycle.
REQ-019 RF_WRITE SHALL be 0 in every cycle following an edge where BUSYWAIT=1.
REQ-020 FSM states: IDLE(00) count==0, no busywait; DRAIN(01) count>0; BLOCKED(10) BUSYWAIT=1; encoding 11 unused, SHALL recover to IDLE.
REQ-021 Transitions: any -> BLOCKED when BUSYWAIT=1; BLOCKED -> DRAIN if count>0 else IDLE when BUSYWAIT=0; IDLE <-> DRAIN on count.
REQ-022 Count SHALL never exceed 2 nor underflow; pointers wrap modulo 2.

Reset
REQ-023 RESET=0 SHALL immediately force RF_WRITE=0, RF_ADDR=0, RF_DATA=0, MEM_GNT=0, count=0, pointers=0, STATE=IDLE.
REQ-024 Reset mid-operation SHALL discard FIFO contents; no write issued on the first edge after release unless a request is present.

Structure
REQ-025 Shared package SHALL hold state encodings, FIFO depth (2), register-address width (3), data width (8).
REQ-026 FIFO SHALL be a sub-module wb_fifo (2-entry, 11-bit, push/pop/full/empty, async active-low reset).

Verification
REQ-027 ALU_REQ addr=3 data=0x2A, idle -> next cycle RF_WRITE=1, RF_ADDR=3, RF_DATA=0x2A, ALU_GNT=1.
REQ-028 MEM_REQ (5,0x11) and ALU_REQ (2,0x07) same edge -> cycle 1 writes r5=0x11 with MEM_GNT=1; cycle 2 writes r2=0x07.
REQ-029 BUSYWAIT=1 for 4 cycles with ALU_REQ every cycle -> 2 enqueued, STALL=1 from 3rd cycle, no RF_WRITE; after release, two FIFO writes in order.
REQ-030 FIFO holds (1,0xA0); MEM_REQ (1,0xB0) arrives -> r1=0xA0 written first, then r1=0xB0 with MEM_GNT.
REQ-031 RESET=0 asserted mid-cycle with count=2 -> outputs zero immediately, STATE=IDLE, no stale writes after release.
REQ-032 Simultaneous dequeue/enqueue with count=1 over 3 cycles -> count stays 1, data issued in arrival order.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The FIFO entry struct is the {addr, data} pair carried by one write.
package reg_wb_arbiter_pkg;
   localparam int AW         = 3;
   localparam int DW         = 8;
   localparam int FIFO_DEPTH = 2;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_DRAIN   = 2'b01;
   localparam logic [1:0] ST_BLOCKED = 2'b10;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo: 2-entry {addr,data} queue holding ALU results that could not
// issue directly. Contents are not reset; only pointers and count are.
module wb_fifo
   import reg_wb_arbiter_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic       push,
   input  logic       pop,
   input  wb_entry_t  din,
   output wb_entry_t  dout,
   output logic       full,
   output logic       empty,
   output logic [1:0] count
);
   wb_entry_t mem [FIFO_DEPTH];
   logic      wr_ptr, rd_ptr;
   logic      do_push, do_pop;

   assign full    = (count == 2'(FIFO_DEPTH));
   assign empty   = (count == 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the single register-file write port between ALU and load writebacks.
// Queued ALU results always write before a pending load; BUSYWAIT blocks all writes.
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
(
   input  logic          CLK,
   input  logic          RESET,
   input  logic          ALU_REQ,
   input  logic [AW-1:0] ALU_ADDR,
   input  logic [DW-1:0] ALU_DATA,
   input  logic          MEM_REQ,
   input  logic [AW-1:0] MEM_ADDR,
   input  logic [DW-1:0] MEM_DATA,
   input  logic          BUSYWAIT,
   output logic          ALU_GNT,
   output logic          MEM_GNT,
   output logic          RF_WRITE,
   output logic [AW-1:0] RF_ADDR,
   output logic [DW-1:0] RF_DATA,
   output logic          STALL,
   output logic [1:0]    STATE
);
   wb_entry_t  alu_ent, mem_ent, head, issue_ent;
   logic       push, pop, full, empty, issue, mem_go;
   logic [1:0] count, cnt_nxt, state_nxt;

   assign alu_ent = '{addr: ALU_ADDR, data: ALU_DATA};
   assign mem_ent = '{addr: MEM_ADDR, data: MEM_DATA};
   assign STALL   = full;
   assign ALU_GNT = ALU_REQ & ~full;

   wb_fifo u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (push),
      .pop   (pop),
      .din   (alu_ent),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // A granted ALU result that loses the port this edge is queued behind the head.
   always_comb begin
      issue     = 1'b0;
      issue_ent = '0;
      mem_go    = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      if (BUSYWAIT) begin
         push = ALU_GNT;
      end else if (!empty) begin
         issue     = 1'b1;
         issue_ent = head;
         pop       = 1'b1;
         push      = ALU_GNT;
      end else if (MEM_REQ) begin
         issue     = 1'b1;
         issue_ent = mem_ent;
         mem_go    = 1'b1;
         push      = ALU_GNT;
      end else if (ALU_GNT) begin
         issue     = 1'b1;
         issue_ent = alu_ent;
      end
   end

   assign cnt_nxt = count + 2'(push) - 2'(pop);

   always_comb begin
      state_nxt = ST_IDLE;
      case (STATE)
         ST_IDLE, ST_DRAIN, ST_BLOCKED:
            if (BUSYWAIT)           state_nxt = ST_BLOCKED;
            else if (cnt_nxt != 0)  state_nxt = ST_DRAIN;
            else                    state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // RF_ADDR/RF_DATA only move on an issued write; they are qualified by RF_WRITE.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         RF_WRITE <= 1'b0;
         RF_ADDR  <= '0;
         RF_DATA  <= '0;
         MEM_GNT  <= 1'b0;
         STATE    <= ST_IDLE;
      end else begin
         RF_WRITE <= issue;
         MEM_GNT  <= mem_go;
         STATE    <= state_nxt;
         if (issue) begin
            RF_ADDR <= issue_ent.addr;
            RF_DATA <= issue_ent.data;
         end
      end
   end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: hand-computed expectations per cycle.
module tb_reg_wb_arbiter;
   logic       CLK = 1'b0;
   logic       RESET;
   logic       ALU_REQ, MEM_REQ, BUSYWAIT;
   logic [2:0] ALU_ADDR, MEM_ADDR;
   logic [7:0] ALU_DATA, MEM_DATA;
   logic       ALU_GNT, MEM_GNT, RF_WRITE, STALL;
   logic [2:0] RF_ADDR;
   logic [7:0] RF_DATA;
   logic [1:0] STATE;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   reg_wb_arbiter dut (
      .CLK(CLK), .RESET(RESET),
      .ALU_REQ(ALU_REQ), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
      .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
      .BUSYWAIT(BUSYWAIT), .ALU_GNT(ALU_GNT), .MEM_GNT(MEM_GNT),
      .RF_WRITE(RF_WRITE), .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
      .STALL(STALL), .STATE(STATE)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic ar, input logic [2:0] aa, input logic [7:0] ad,
                        input logic mr, input logic [2:0] ma, input logic [7:0] md,
                        input logic bw);
      ALU_REQ = ar; ALU_ADDR = aa; ALU_DATA = ad;
      MEM_REQ = mr; MEM_ADDR = ma; MEM_DATA = md;
      BUSYWAIT = bw;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [2:0] a,
                         input logic [7:0] d, input logic mg);
      chk({tag, ".we"}, 32'(RF_WRITE), 32'(we));
      chk({tag, ".mg"}, 32'(MEM_GNT), 32'(mg));
      if (we) begin
         chk({tag, ".addr"}, 32'(RF_ADDR), 32'(a));
         chk({tag, ".data"}, 32'(RF_DATA), 32'(d));
      end
   endtask

   initial begin
      RESET = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst.we", 32'(RF_WRITE), 0);
      chk("rst.addr", 32'(RF_ADDR), 0);
      chk("rst.data", 32'(RF_DATA), 0);
      chk("rst.mg", 32'(MEM_GNT), 0);
      chk("rst.state", 32'(STATE), 0);
      chk("rst.stall", 32'(STALL), 0);
      @(negedge CLK);
      RESET = 1'b1;
      tick();

      // Idle ALU writeback goes straight to the port
      drive(1, 3, 8'h2A, 0, 0, 0, 0);
      #1;
      chk("alu.gnt", 32'(ALU_GNT), 1);
      chk("alu.stall", 32'(STALL), 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_wr("alu.wr", 1, 3, 8'h2A, 0);
      chk("alu.state", 32'(STATE), 0);
      tick();
      chk_wr("alu.idle", 0, 0, 0, 0);

      // Load wins over a fresh ALU result; ALU result queued behind it
      drive(1, 2, 8'h07, 1, 5, 8'h11, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_wr("both.c1", 1, 5, 8'h11, 1);
      chk("both.st1", 32'(STATE), 1);
      tick();
      chk_wr("both.c2", 1, 2, 8'h07, 0);
      chk("both.st2", 32'(STATE), 0);
      tick();
      chk_wr("both.c3", 0, 0, 0, 0);

      // Busywait: two results queue, then stall, then in-order drain
      for (int i = 1; i <= 4; i++) begin
         drive(1, 3'(i), 8'(8'h40 + i), 0, 0, 0, 1);
         #1;
         chk("bw.stall", 32'(STALL), 32'(i >= 3));
         chk("bw.gnt", 32'(ALU_GNT), 32'(i < 3));
         tick();
         chk("bw.we", 32'(RF_WRITE), 0);
         chk("bw.state", 32'(STATE), 2);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("bw.stall_hold", 32'(STALL), 1);
      tick();
      chk_wr("bw.d1", 1, 1, 8'h41, 0);
      chk("bw.st_d1", 32'(STATE), 1);
      tick();
      chk_wr("bw.d2", 1, 2, 8'h42, 0);
      chk("bw.st_d2", 32'(STATE), 0);
      tick();
      chk_wr("bw.d3", 0, 0, 0, 0);

      // Queued ALU result to r1 writes before the held load to r1
      drive(1, 1, 8'hA0, 1, 1, 8'hB0, 1);
      tick();
      chk_wr("ord.blk", 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 8'hB0, 0);
      tick();
      chk_wr("ord.fifo", 1, 1, 8'hA0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_wr("ord.load", 1, 1, 8'hB0, 1);
      tick();
      chk_wr("ord.idle", 0, 0, 0, 0);

      // Count held at 1 by concurrent enqueue/dequeue
      drive(1, 0, 8'h10, 0, 0, 0, 1);
      tick();
      for (int i = 1; i <= 3; i++) begin
         drive(1, 3'(i), 8'(8'h10 + i), 0, 0, 0, 0);
         #1;
         chk("sim.gnt", 32'(ALU_GNT), 1);
         tick();
         chk_wr("sim.wr", 1, 3'(i - 1), 8'(8'h10 + i - 1), 0);
         chk("sim.state", 32'(STATE), 1);
         chk("sim.stall", 32'(STALL), 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_wr("sim.last", 1, 3, 8'h13, 0);
      chk("sim.st_end", 32'(STATE), 0);
      tick();
      chk_wr("sim.idle", 0, 0, 0, 0);

      // Reset mid-cycle with a full FIFO
      drive(1, 3, 8'h33, 0, 0, 0, 0);
      tick();
      drive(1, 6, 8'hC6, 0, 0, 0, 1);
      tick();
      drive(1, 7, 8'hC7, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("mrst.stall", 32'(STALL), 1);
      chk("mrst.addr_held", 32'(RF_ADDR), 3);
      chk("mrst.data_held", 32'(RF_DATA), 32'h33);
      #2;
      RESET = 1'b0;
      #1;
      chk("mrst.we", 32'(RF_WRITE), 0);
      chk("mrst.addr", 32'(RF_ADDR), 0);
      chk("mrst.data", 32'(RF_DATA), 0);
      chk("mrst.mg", 32'(MEM_GNT), 0);
      chk("mrst.state", 32'(STATE), 0);
      chk("mrst.stall", 32'(STALL), 0);
      tick();
      @(negedge CLK);
      RESET = 1'b1;
      tick();
      chk_wr("mrst.rel1", 0, 0, 0, 0);
      chk("mrst.st1", 32'(STATE), 0);
      tick();
      chk_wr("mrst.rel2", 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
